// File: rtl/sdio_dma_ctrl.sv
// Byte-wide bus-master DMA between the memory bus and the SDIO TX/RX FIFOs.
// One bus transaction is outstanding at a time; blk_cnt blocks of blk_len bytes are moved from a linear address.
`timescale 1ns/1ps
module sdio_dma_ctrl #(
  parameter int AW = 16,
  parameter int LW = 12,
  parameter int CW = 9
) (
  input  logic          bus_clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          dir,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] blk_len,
  input  logic [CW-1:0] blk_cnt,
  input  logic          bus_ready,
  input  logic          bus_rdata_ready,
  input  logic [7:0]    bus_rdata,
  output logic [AW-1:0] bus_addr,
  output logic [7:0]    bus_wdata,
  output logic          bus_rd,
  output logic          bus_wr,
  output logic          tx_wr,
  output logic [7:0]    tx_wdata,
  input  logic          tx_full,
  output logic          rx_rd,
  input  logic [7:0]    rx_rdata,
  input  logic          rx_empty,
  output logic          dma_busy,
  output logic          blk_done,
  output logic          dma_done
);

  // state     | meaning
  // S_IDLE    | waiting for start
  // S_RD_REQ  | memory read request, issued once the TX FIFO has room
  // S_RD_WAIT | waiting for read data, forwarded straight into the TX FIFO
  // S_WR_POP  | waiting for a byte in the RX FIFO, pop it
  // S_WR_LAT  | RX FIFO data arrives, capture it as write data
  // S_WR_REQ  | memory write request
  // S_ADV     | advance address and byte/block counters
  // S_DONE    | end of transfer (normal or aborted)
  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_POP, S_WR_LAT, S_WR_REQ, S_ADV, S_DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] addr;
  logic [LW-1:0] byte_cnt;
  logic [LW-1:0] len_r;
  logic [CW-1:0] blk_left;
  logic          dir_r;
  logic          rd_hold;
  logic          abort_pend;
  logic          blk_last;

  assign blk_last = (byte_cnt + LW'(1)) == len_r;

  // Once a read request is presented it stays up until accepted, even if tx_full rises meanwhile.
  assign bus_addr = addr;
  assign bus_rd   = (state == S_RD_REQ) && !abort && (rd_hold || !tx_full);
  assign bus_wr   = (state == S_WR_REQ) && !abort;
  assign rx_rd    = (state == S_WR_POP) && !abort && !rx_empty;
  assign tx_wr    = (state == S_RD_WAIT) && bus_rdata_ready && !abort && !abort_pend;
  assign tx_wdata = tx_wr ? bus_rdata : 8'h00;

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      byte_cnt   <= '0;
      len_r      <= '0;
      blk_left   <= '0;
      dir_r      <= 1'b0;
      rd_hold    <= 1'b0;
      abort_pend <= 1'b0;
      bus_wdata  <= 8'h00;
      dma_busy   <= 1'b0;
      blk_done   <= 1'b0;
      dma_done   <= 1'b0;
    end else begin
      blk_done <= 1'b0;
      dma_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (blk_len == '0 || blk_cnt == '0) begin
              dma_done <= 1'b1;
            end else begin
              addr     <= base_addr;
              len_r    <= blk_len;
              blk_left <= blk_cnt;
              dir_r    <= dir;
              byte_cnt <= '0;
              dma_busy <= 1'b1;
              state    <= dir ? S_WR_POP : S_RD_REQ;
            end
          end
        end
        S_RD_REQ: begin
          if (abort) begin
            rd_hold  <= 1'b0;
            state    <= S_DONE;
            dma_done <= 1'b1;
            dma_busy <= 1'b0;
          end else if (bus_rd) begin
            if (bus_ready) begin
              rd_hold <= 1'b0;
              state   <= S_RD_WAIT;
            end else begin
              rd_hold <= 1'b1;
            end
          end
        end
        S_RD_WAIT: begin
          if (abort) abort_pend <= 1'b1;
          // An aborted read still has to drain its data beat before the bus is free.
          if (bus_rdata_ready) begin
            if (abort || abort_pend) begin
              abort_pend <= 1'b0;
              state      <= S_DONE;
              dma_done   <= 1'b1;
              dma_busy   <= 1'b0;
            end else begin
              state <= S_ADV;
            end
          end
        end
        S_WR_POP: begin
          if (abort) begin
            state    <= S_DONE;
            dma_done <= 1'b1;
            dma_busy <= 1'b0;
          end else if (!rx_empty) begin
            state <= S_WR_LAT;
          end
        end
        S_WR_LAT: begin
          if (abort) begin
            state    <= S_DONE;
            dma_done <= 1'b1;
            dma_busy <= 1'b0;
          end else begin
            bus_wdata <= rx_rdata;
            state     <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (abort) begin
            state    <= S_DONE;
            dma_done <= 1'b1;
            dma_busy <= 1'b0;
          end else if (bus_ready) begin
            state <= S_ADV;
          end
        end
        S_ADV: begin
          addr <= addr + AW'(1);
          if (abort) begin
            state    <= S_DONE;
            dma_done <= 1'b1;
            dma_busy <= 1'b0;
          end else if (blk_last) begin
            byte_cnt <= '0;
            blk_done <= 1'b1;
            blk_left <= blk_left - CW'(1);
            if (blk_left == CW'(1)) begin
              state    <= S_DONE;
              dma_done <= 1'b1;
              dma_busy <= 1'b0;
            end else begin
              state <= dir_r ? S_WR_POP : S_RD_REQ;
            end
          end else begin
            byte_cnt <= byte_cnt + LW'(1);
            state    <= dir_r ? S_WR_POP : S_RD_REQ;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdio_dma_ctrl.sv
// Scoreboard bench for sdio_dma_ctrl: a transfer-level model queues the expected bus, FIFO and
// completion events; a memory slave / FIFO model answers the DUT and a monitor pops and compares.
`timescale 1ns/1ps
module tb_sdio_dma_ctrl;
  localparam int AW = 16;
  localparam int LW = 12;
  localparam int CW = 9;

  logic          bus_clk = 1'b0;
  logic          rst;
  logic          start, abort, dir;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] blk_len;
  logic [CW-1:0] blk_cnt;
  logic          bus_ready, bus_rdata_ready;
  logic [7:0]    bus_rdata;
  logic [AW-1:0] bus_addr;
  logic [7:0]    bus_wdata;
  logic          bus_rd, bus_wr, tx_wr;
  logic [7:0]    tx_wdata;
  logic          tx_full, rx_rd, rx_empty;
  logic [7:0]    rx_rdata;
  logic          dma_busy, blk_done, dma_done;

  always #5 bus_clk = ~bus_clk;

  sdio_dma_ctrl #(.AW(AW), .LW(LW), .CW(CW)) dut (
    .bus_clk(bus_clk), .rst(rst), .start(start), .abort(abort), .dir(dir),
    .base_addr(base_addr), .blk_len(blk_len), .blk_cnt(blk_cnt),
    .bus_ready(bus_ready), .bus_rdata_ready(bus_rdata_ready), .bus_rdata(bus_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .tx_wr(tx_wr), .tx_wdata(tx_wdata), .tx_full(tx_full),
    .rx_rd(rx_rd), .rx_rdata(rx_rdata), .rx_empty(rx_empty),
    .dma_busy(dma_busy), .blk_done(blk_done), .dma_done(dma_done)
  );

  typedef struct { logic [15:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int bytes; int kind; int cyc; } done_t;  // kind: 0 any time, 1 at cyc, 2 one cycle after read data

  logic [15:0] exp_rd[$];
  logic [7:0]  exp_tx[$];
  wr_t         exp_wr[$];
  int          exp_blk[$];
  done_t       exp_done[$];
  logic [7:0]  rx_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int bytes_done = 0, rd_accepts = 0, tx_count = 0, done_count = 0, last_rdv_cyc = -10;

  int ready_wait = 0, rdata_lat = 1, full_hold = 0;
  bit rand_full = 1'b0, rand_rx = 1'b0;

  always @(posedge bus_clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got unexpected event value %0h expected no event (cycle %0d)", name, act, cyc);
  endtask

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return (a[7:0] * 8'd13) ^ a[15:8] ^ 8'h96;
  endfunction

  // Memory slave and FIFO models
  initial begin
    logic [15:0] rd_addr;
    logic [7:0]  rx_hold;
    int          rd_cnt, req_wait;
    bit          rx_pending, saw_tx;
    rd_addr = '0; rx_hold = '0; rd_cnt = 0; req_wait = 0; rx_pending = 0; saw_tx = 0;
    bus_ready = 0; bus_rdata_ready = 0; bus_rdata = 0; rx_rdata = 0; rx_empty = 1; tx_full = 0;
    forever begin
      @(posedge bus_clk); #2;
      if (rx_pending) begin rx_rdata = rx_hold; rx_pending = 0; end
      rx_empty = (rx_q.size() == 0) || (rand_rx && $urandom_range(3) == 0);
      if (full_hold > 0) begin
        tx_full = 1'b1;
        full_hold--;
      end else if (rand_full) begin
        // the FIFO fills only through our own pushes, and drains at random
        tx_full = tx_full ? ($urandom_range(2) != 0) : (saw_tx && $urandom_range(2) == 0);
      end else begin
        tx_full = 1'b0;
      end
      #1;
      bus_ready = 0;
      bus_rdata_ready = 0;
      bus_rdata = 8'($urandom);
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin bus_rdata_ready = 1; bus_rdata = mem_byte(rd_addr); end
      end
      if (bus_rd || bus_wr) begin
        if (req_wait >= ready_wait) begin
          bus_ready = 1;
          req_wait = 0;
          if (bus_rd) begin rd_cnt = rdata_lat; rd_addr = bus_addr; end
        end else begin
          req_wait++;
        end
      end else begin
        req_wait = 0;
      end
      if (rx_rd && rx_q.size() > 0) begin rx_hold = rx_q.pop_front(); rx_pending = 1; end
      saw_tx = tx_wr;
    end
  end

  // Monitor / scoreboard
  initial begin
    logic        prev_rd, prev_wr, prev_ready;
    logic [15:0] prev_addr;
    logic [7:0]  prev_wdata;
    wr_t         w;
    done_t       d;
    prev_rd = 0; prev_wr = 0; prev_ready = 0; prev_addr = 0; prev_wdata = 0;
    forever begin
      @(negedge bus_clk);
      if (rst) continue;
      if (bus_rd || bus_wr || rx_rd) begin
        chk("bus_rd_wr_exclusive", 32'(bus_rd & bus_wr), 0);
        chk("busy_during_access", 32'(dma_busy), 1);
      end
      if (bus_rd && !prev_rd) chk("rd_issued_while_full", 32'(tx_full), 0);
      if (prev_rd && !prev_ready && !abort) begin
        chk("rd_held_until_ready", 32'(bus_rd), 1);
        chk("rd_addr_stable", 32'(bus_addr), 32'(prev_addr));
      end
      if (prev_wr && !prev_ready && !abort) begin
        chk("wr_held_until_ready", 32'(bus_wr), 1);
        chk("wr_addr_stable", 32'(bus_addr), 32'(prev_addr));
        chk("wr_data_stable", 32'(bus_wdata), 32'(prev_wdata));
      end
      if (bus_rd && bus_ready) begin
        if (exp_rd.size() == 0) unexpected("rd_txn", 32'(bus_addr));
        else chk("rd_addr", 32'(bus_addr), 32'(exp_rd.pop_front()));
        rd_accepts++;
      end
      if (bus_wr && bus_ready) begin
        if (exp_wr.size() == 0) unexpected("wr_txn", 32'(bus_addr));
        else begin
          w = exp_wr.pop_front();
          chk("wr_addr", 32'(bus_addr), 32'(w.addr));
          chk("wr_data", 32'(bus_wdata), 32'(w.data));
        end
        bytes_done++;
      end
      if (tx_wr) begin
        chk("tx_wr_while_full", 32'(tx_full), 0);
        if (exp_tx.size() == 0) unexpected("tx_wr", 32'(tx_wdata));
        else chk("tx_data", 32'(tx_wdata), 32'(exp_tx.pop_front()));
        tx_count++;
        bytes_done++;
      end
      if (blk_done) begin
        if (exp_blk.size() == 0) unexpected("blk_done", 32'(bytes_done));
        else chk("blk_done_position", 32'(bytes_done), 32'(exp_blk.pop_front()));
      end
      if (dma_done) begin
        if (exp_done.size() == 0) unexpected("dma_done", 32'(bytes_done));
        else begin
          d = exp_done.pop_front();
          chk("done_byte_count", 32'(bytes_done), 32'(d.bytes));
          chk("done_busy_low", 32'(dma_busy), 0);
          if (d.kind == 1) chk("done_latency", 32'(cyc), 32'(d.cyc));
          if (d.kind == 2) chk("abort_done_latency", 32'(cyc), 32'(last_rdv_cyc + 1));
        end
        done_count++;
      end
      if (bus_rdata_ready) last_rdv_cyc = cyc;
      prev_rd = bus_rd; prev_wr = bus_wr; prev_ready = bus_ready;
      prev_addr = bus_addr; prev_wdata = bus_wdata;
    end
  end

  task automatic tick();
    @(posedge bus_clk); #1;
  endtask

  task automatic pulse_start(input bit d, input logic [15:0] base, input int len, input int cnt);
    start = 1; dir = d; base_addr = base; blk_len = LW'(len); blk_cnt = CW'(cnt);
    tick();
    start = 0;
  endtask

  // Reference model: the whole transfer expressed as lists of byte addresses and data.
  task automatic issue_xfer(input bit d, input logic [15:0] base, input int len, input int cnt, input int rx_first);
    int n, b0;
    logic [15:0] a;
    logic [7:0]  v;
    n = len * cnt;
    b0 = bytes_done;
    for (int i = 0; i < n; i++) begin
      a = base + 16'(i);
      if (!d) begin
        exp_rd.push_back(a);
        exp_tx.push_back(mem_byte(a));
      end else begin
        v = (rx_first < 0) ? 8'($urandom) : 8'(rx_first + i);
        rx_q.push_back(v);
        exp_wr.push_back('{addr: a, data: v});
      end
    end
    for (int b = 0; b < cnt && n > 0; b++) exp_blk.push_back(b0 + len * (b + 1));
    exp_done.push_back('{bytes: b0 + n, kind: (n == 0) ? 1 : 0, cyc: cyc + 1});
    pulse_start(d, base, len, cnt);
  endtask

  task automatic wait_done(input int target, input int budget);
    int t;
    t = 0;
    while (done_count < target && t < budget) begin tick(); t++; end
    chk("done_within_budget", 32'(done_count >= target), 1);
  endtask

  task automatic settle_check(input string name);
    repeat (6) tick();
    chk(name, 32'(exp_rd.size() + exp_tx.size() + exp_wr.size() + exp_blk.size() + exp_done.size()), 0);
  endtask

  task automatic xfer(input bit d, input logic [15:0] base, input int len, input int cnt, input int rx_first);
    int d0;
    d0 = done_count;
    issue_xfer(d, base, len, cnt, rx_first);
    wait_done(d0 + 1, 40 * (len * cnt + 4) + 200);
    settle_check("leftover_expectations");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, r0, t, len, cnt;
    bit rd_dir;
    logic [15:0] base;
    rst = 1; start = 0; abort = 0; dir = 0; base_addr = '0; blk_len = '0; blk_cnt = '0;
    repeat (3) @(posedge bus_clk);
    @(negedge bus_clk);
    chk("reset_bus_rd", 32'(bus_rd), 0);
    chk("reset_bus_wr", 32'(bus_wr), 0);
    chk("reset_tx_wr", 32'(tx_wr), 0);
    chk("reset_rx_rd", 32'(rx_rd), 0);
    chk("reset_dma_busy", 32'(dma_busy), 0);
    chk("reset_blk_done", 32'(blk_done), 0);
    chk("reset_dma_done", 32'(dma_done), 0);
    chk("reset_bus_addr", 32'(bus_addr), 0);
    chk("reset_bus_wdata", 32'(bus_wdata), 0);
    chk("reset_tx_wdata", 32'(tx_wdata), 0);
    tick();
    rst = 0;
    repeat (2) tick();

    // card write, two blocks, zero-wait slave
    xfer(1'b0, 16'h0100, 4, 2, -1);

    // card read with address wrap
    xfer(1'b1, 16'hFFFE, 4, 1, 8'hA0);

    // TX FIFO full for 20 cycles mid-block, slow slave
    ready_wait = 3;
    d0 = done_count;
    issue_xfer(1'b0, 16'h0200, 8, 1, -1);
    t = 0;
    while (tx_count < 3 && t < 500) begin tick(); t++; end
    full_hold = 20;
    wait_done(d0 + 1, 1000);
    settle_check("leftover_after_full");
    ready_wait = 0;

    // abort while a read is outstanding, data returns 5 cycles after accept
    rdata_lat = 5;
    d0 = done_count;
    r0 = rd_accepts;
    for (int i = 0; i < 3; i++) begin
      exp_rd.push_back(16'h0300 + 16'(i));
      if (i < 2) exp_tx.push_back(mem_byte(16'h0300 + 16'(i)));
    end
    exp_done.push_back('{bytes: bytes_done + 2, kind: 2, cyc: 0});
    pulse_start(1'b0, 16'h0300, 4, 2);
    t = 0;
    while (rd_accepts < r0 + 3 && t < 500) begin tick(); t++; end
    chk("abort_read_reached", 32'(rd_accepts), 32'(r0 + 3));
    abort = 1;
    tick();
    abort = 0;
    wait_done(d0 + 1, 100);
    settle_check("leftover_after_abort");
    rdata_lat = 1;

    // abort in idle does nothing
    abort = 1;
    tick();
    abort = 0;
    settle_check("abort_idle_no_event");

    // zero-sized transfers
    xfer(1'b0, 16'h0500, 4, 0, -1);
    xfer(1'b1, 16'h0600, 0, 3, -1);

    // second start during a transfer is ignored
    d0 = done_count;
    issue_xfer(1'b0, 16'h0400, 3, 2, -1);
    repeat (5) tick();
    pulse_start(1'b1, 16'h9000, 7, 5);
    wait_done(d0 + 1, 500);
    repeat (30) tick();
    chk("second_start_ignored_done_count", 32'(done_count), 32'(d0 + 1));
    settle_check("leftover_after_second_start");

    // randomized transfers
    rand_full = 1'b1;
    rand_rx = 1'b1;
    for (int k = 0; k < 12; k++) begin
      rd_dir = 1'($urandom_range(1));
      base = (k % 4 == 3) ? 16'hFFFC : 16'($urandom);
      len = $urandom_range(1, 6);
      cnt = $urandom_range(1, 3);
      ready_wait = $urandom_range(0, 2);
      rdata_lat = $urandom_range(1, 3);
      xfer(rd_dir, base, len, cnt, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
